// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state type, index-width helper and 12 MHz timing defaults for the key matrix scanner
package keypad_pkg;
    typedef enum logic {DRIVE, EVAL} scan_state_t;
    localparam int CLK_HZ = 12_000_000;
    localparam int DEF_SETTLE_CYCLES = CLK_HZ / 1000;
    localparam int DEF_DEBOUNCE_SCANS = 8;
    function automatic int key_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: matrix pins plus debounced key outputs; master is the scanner, slave the consumer
interface keypad_scan_ctrl_if import keypad_pkg::*; #(
    parameter int NUM_COLS = 2,
    parameter int NUM_ROWS = 2
);
    localparam int NK = NUM_COLS * NUM_ROWS;
    logic [NUM_ROWS-1:0] row_in;
    logic [NUM_COLS-1:0] col_out;
    logic [NK-1:0] key_map;
    logic key_valid;
    logic [key_w(NK)-1:0] key_code;
    logic key_multi;
    modport master (input row_in, output col_out, key_map, key_valid, key_code, key_multi);
    modport slave (output row_in, input col_out, key_map, key_valid, key_code, key_multi);
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level debounce of the raw key bitmap with new-press detection
module keypad_debounce import keypad_pkg::*; #(
    parameter int NK = 4,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic frame_done,
    input  logic [NK-1:0] raw,
    output logic [NK-1:0] key_map,
    output logic key_valid,
    output logic [key_w(NK)-1:0] key_code,
    output logic key_multi
);
    localparam int KW = key_w(NK);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    logic [NK-1:0] prev_raw, fresh;
    logic [SW-1:0] stable, stable_nx;
    logic [KW-1:0] low;
    always_comb begin
        stable_nx = raw == prev_raw ? (stable == SW'(DEBOUNCE_SCANS) ? stable : stable + SW'(1)) : SW'(1);
        fresh = raw & ~key_map;
        low = '0;
        for (int i = NK - 1; i >= 0; i--) if (fresh[i]) low = KW'(i);
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_raw <= '0;
            stable <= '0;
            key_map <= '0;
            key_valid <= 1'b0;
            key_code <= '0;
            key_multi <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_done) begin
                prev_raw <= raw;
                stable <= stable_nx;
                if (stable_nx == SW'(DEBOUNCE_SCANS)) begin
                    key_map <= raw;
                    // clearing the lowest set bit leaves something only if two or more keys are new
                    if (|fresh) begin
                        key_valid <= 1'b1;
                        key_code <= low;
                        key_multi <= |(fresh & (fresh - NK'(1)));
                    end
                end
            end
        end
    end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column sequencer, row synchronizer and frame assembly feeding the debouncer
module keypad_scan_ctrl import keypad_pkg::*; #(
    parameter int NUM_COLS = 2,
    parameter int NUM_ROWS = 2,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
    input logic CLK,
    input logic RST,
    keypad_scan_ctrl_if.master bus
);
    localparam int NK = NUM_COLS * NUM_ROWS;
    localparam int CW = key_w(NUM_COLS);
    localparam int TW = $clog2(SETTLE_CYCLES);
    scan_state_t state;
    logic [NUM_ROWS-1:0] sync1, sync2;
    logic [CW-1:0] col;
    logic [TW-1:0] cnt;
    logic [NK-1:0] raw;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= DRIVE;
            sync1 <= '0;
            sync2 <= '0;
            col <= '0;
            cnt <= '0;
            raw <= '0;
            bus.col_out <= NUM_COLS'(1);
        end else begin
            sync1 <= bus.row_in;
            sync2 <= sync1;
            if (state == DRIVE) begin
                // sample and column advance share the last settle cycle, keeping the frame at NUM_COLS*SETTLE_CYCLES+1
                if (cnt == TW'(SETTLE_CYCLES - 1)) begin
                    raw[int'(col) * NUM_ROWS +: NUM_ROWS] <= sync2;
                    cnt <= '0;
                    if (col == CW'(NUM_COLS - 1)) state <= EVAL;
                    else begin
                        col <= col + CW'(1);
                        bus.col_out <= bus.col_out << 1;
                    end
                end else cnt <= cnt + TW'(1);
            end else begin
                state <= DRIVE;
                col <= '0;
                bus.col_out <= NUM_COLS'(1);
            end
        end
    end
    keypad_debounce #(.NK(NK), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
        .CLK(CLK),
        .RST(RST),
        .frame_done(state == EVAL),
        .raw(raw),
        .key_map(bus.key_map),
        .key_valid(bus.key_valid),
        .key_code(bus.key_code),
        .key_multi(bus.key_multi)
    );
endmodule
